// File: rtl/fmq_pkg.sv
// Shared constants for the host-side command sender: command word layout,
// response status codes and the sender FSM state encoding.
package fmq_pkg;

    localparam int CMD_WIDTH    = 24;
    localparam int CMD_MARK_BIT = 23;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_MISMATCH = 2'b01;
    localparam logic [1:0] ST_TIMEOUT  = 2'b10;
    localparam logic [1:0] ST_BADCMD   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND0     = 3'd1,
        S_SEND1     = 3'd2,
        S_SEND2     = 3'd3,
        S_WAIT_ECHO = 3'd4,
        S_RESP      = 3'd5
    } state_t;

endpackage

// File: rtl/cmd_timeout_timer.sv
// Saturating echo-wait timer: cleared while the sender is not waiting, counts
// up while enabled and flags expiry once it reaches TIMEOUT_CYCLES-1.
module cmd_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] CNT_MAX = '1;

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && count != CNT_MAX) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count >= LAST);

endmodule

// File: rtl/cmd_sender.sv
// Serialises a 24-bit command MSB-byte-first onto a byte stream, then waits
// for the device's one-byte echo and reports ok/mismatch/timeout/bad-command.
module cmd_sender
    import fmq_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int CLOCK          = 50000000,
    parameter int TIMEOUT_CYCLES = CLOCK / 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [23:0]           cmd_data,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    output logic                  resp_valid,
    output logic [1:0]            resp_status,
    output logic [7:0]            resp_echo,
    output logic                  busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; a source keeps valid and data stable until then, and
    // while rst is high every handshake output is held inactive.

    state_t          state, state_n;
    logic [CMD_WIDTH-1:0] cmd_q;
    logic            load_resp;
    logic [1:0]      status_d;
    logic [7:0]      echo_d;
    logic            timer_expired;

    cmd_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != S_WAIT_ECHO),
        .enable  (state == S_WAIT_ECHO),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cmd_q       <= '0;
            resp_status <= ST_OK;
            resp_echo   <= '0;
        end else begin
            state <= state_n;
            if (cmd_valid && cmd_ready) begin
                cmd_q <= cmd_data;
            end
            if (load_resp) begin
                resp_status <= status_d;
                resp_echo   <= echo_d;
            end
        end
    end

    always_comb begin
        state_n            = state;
        cmd_ready          = 1'b0;
        output_axis_tvalid = 1'b0;
        output_axis_tdata  = '0;
        input_axis_tready  = 1'b0;
        resp_valid         = 1'b0;
        busy               = (state != S_IDLE);
        load_resp          = 1'b0;
        status_d           = ST_OK;
        echo_d             = '0;

        case (state)
            S_IDLE: begin
                cmd_ready         = 1'b1;
                input_axis_tready = 1'b1;  // stray RX bytes are drained here
                if (cmd_valid) begin
                    if (cmd_data[CMD_MARK_BIT]) begin
                        state_n = S_SEND0;
                    end else begin
                        load_resp = 1'b1;
                        status_d  = ST_BADCMD;
                        state_n   = S_RESP;
                    end
                end
            end
            S_SEND0: begin
                output_axis_tvalid = 1'b1;
                output_axis_tdata  = cmd_q[23:16];
                if (output_axis_tready) state_n = S_SEND1;
            end
            S_SEND1: begin
                output_axis_tvalid = 1'b1;
                output_axis_tdata  = cmd_q[15:8];
                if (output_axis_tready) state_n = S_SEND2;
            end
            S_SEND2: begin
                output_axis_tvalid = 1'b1;
                output_axis_tdata  = cmd_q[7:0];
                if (output_axis_tready) state_n = S_WAIT_ECHO;
            end
            S_WAIT_ECHO: begin
                input_axis_tready = 1'b1;
                // An echo arriving on the expiry cycle takes priority.
                if (input_axis_tvalid) begin
                    load_resp = 1'b1;
                    echo_d    = input_axis_tdata;
                    status_d  = (input_axis_tdata == cmd_q[23:16]) ? ST_OK : ST_MISMATCH;
                    state_n   = S_RESP;
                end else if (timer_expired) begin
                    load_resp = 1'b1;
                    status_d  = ST_TIMEOUT;
                    state_n   = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_n    = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        if (rst) begin
            cmd_ready          = 1'b0;
            output_axis_tvalid = 1'b0;
            output_axis_tdata  = '0;
            input_axis_tready  = 1'b0;
            resp_valid         = 1'b0;
            busy               = 1'b0;
            load_resp          = 1'b0;
        end
    end

endmodule

// File: tb/tb_cmd_sender.sv
// Directed bench for cmd_sender: byte serialisation, stalls, echo match and
// mismatch, timeout, bad command, stray RX bytes and mid-transfer reset.
module tb_cmd_sender;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] cmd_data = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  output_axis_tdata;
    logic        output_axis_tvalid;
    logic        output_axis_tready = 1'b1;
    logic [7:0]  input_axis_tdata = '0;
    logic        input_axis_tvalid = 1'b0;
    logic        input_axis_tready;
    logic        resp_valid;
    logic [1:0]  resp_status;
    logic [7:0]  resp_echo;
    logic        busy;

    int tests = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    cmd_sender #(
        .DATA_WIDTH(8),
        .CLOCK(10000),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .cmd_data           (cmd_data),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .output_axis_tdata  (output_axis_tdata),
        .output_axis_tvalid (output_axis_tvalid),
        .output_axis_tready (output_axis_tready),
        .input_axis_tdata   (input_axis_tdata),
        .input_axis_tvalid  (input_axis_tvalid),
        .input_axis_tready  (input_axis_tready),
        .resp_valid         (resp_valid),
        .resp_status        (resp_status),
        .resp_echo          (resp_echo),
        .busy               (busy)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one command at a negedge; returns at the negedge after acceptance.
    task automatic accept_cmd(input logic [23:0] cmd);
        cmd_data  = cmd;
        cmd_valid = 1'b1;
        #1;
        check("cmd_ready_idle", cmd_ready, 1'b1);
        if (cmd[23]) begin
            exp_q.push_back(cmd[23:16]);
            exp_q.push_back(cmd[15:8]);
            exp_q.push_back(cmd[7:0]);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Sink three bytes with `stall` cycles of tready low before each one.
    task automatic collect_bytes(input int stall);
        logic [7:0] b;
        for (int i = 0; i < 3; i++) begin
            for (int s = 0; s < stall; s++) begin
                output_axis_tready = 1'b0;
                #1;
                check("hold_valid", output_axis_tvalid, 1'b1);
                check("hold_data", output_axis_tdata, exp_q[0]);
                @(negedge clk);
            end
            output_axis_tready = 1'b1;
            #1;
            check("byte_valid", output_axis_tvalid, 1'b1);
            check("exp_q_nonempty", exp_q.size() != 0, 1'b1);
            b = exp_q.pop_front();
            check("byte_data", output_axis_tdata, b);
            @(negedge clk);
        end
        #1;
        check("wait_no_tvalid", output_axis_tvalid, 1'b0);
        check("wait_rx_ready", input_axis_tready, 1'b1);
        check("wait_busy", busy, 1'b1);
    endtask

    // Called at the WAIT_ECHO entry cycle (k=0); optional echo driven at k=delay.
    task automatic wait_resp(input bit do_echo, input int delay, input logic [7:0] echo,
                             input int exp_lat, input logic [1:0] exp_st, input logic [7:0] exp_echo);
        bit found = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            input_axis_tvalid = do_echo && (k == delay);
            input_axis_tdata  = echo;
            #1;
            if (output_axis_tvalid) check("extra_byte", output_axis_tvalid, 1'b0);
            if (resp_valid) begin
                found = 1;
                check("resp_latency", k, exp_lat);
                check("resp_status", resp_status, exp_st);
                check("resp_echo", resp_echo, exp_echo);
            end
            @(negedge clk);
        end
        input_axis_tvalid = 1'b0;
        check("resp_seen", found, 1'b1);
        #1;
        check("resp_one_cycle", resp_valid, 1'b0);
        check("back_idle_busy", busy, 1'b0);
        check("back_idle_ready", cmd_ready, 1'b1);
        check("status_held", resp_status, exp_st);
        @(negedge clk);
    endtask

    initial begin
        // reset
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_tvalid", output_axis_tvalid, 1'b0);
        check("rst_rx_ready", input_axis_tready, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_status", resp_status, 2'b00);
        check("rst_echo", resp_echo, 8'h00);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("idle_cmd_ready", cmd_ready, 1'b1);
        check("idle_tdata", output_axis_tdata, 8'h00);
        @(negedge clk);

        // T1: matching echo 20 cycles into WAIT_ECHO, no stalls
        accept_cmd(24'h810A14);
        collect_bytes(0);
        wait_resp(1, 20, 8'h81, 21, 2'b00, 8'h81);

        // T2: stalled bytes, wrong echo
        accept_cmd(24'h8500FF);
        collect_bytes(5);
        wait_resp(1, 7, 8'h84, 8, 2'b01, 8'h84);

        // T3: no echo -> timeout exactly TO cycles after WAIT_ECHO entry
        accept_cmd(24'h901234);
        collect_bytes(0);
        wait_resp(0, 0, 8'h00, TO, 2'b10, 8'h00);

        // T4: marker bit clear -> bad command, nothing sent
        accept_cmd(24'h7F0000);
        #1;
        check("bad_no_tvalid", output_axis_tvalid, 1'b0);
        check("bad_resp_valid", resp_valid, 1'b1);
        check("bad_status", resp_status, 2'b11);
        check("bad_echo", resp_echo, 8'h00);
        @(negedge clk);
        #1;
        check("bad_resp_one_cycle", resp_valid, 1'b0);
        check("bad_no_tvalid2", output_axis_tvalid, 1'b0);

        // T5: stray RX byte in IDLE is drained silently
        input_axis_tdata  = 8'h55;
        input_axis_tvalid = 1'b1;
        #1;
        check("stray_rx_ready", input_axis_tready, 1'b1);
        @(negedge clk);
        input_axis_tvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stray_no_resp", resp_valid, 1'b0);
            check("stray_idle", busy, 1'b0);
            @(negedge clk);
        end
        check("stray_status_held", resp_status, 2'b11);

        // T6: reset during SEND1
        accept_cmd(24'h810A14);
        #1;
        check("r_byte0", output_axis_tdata, 8'h81);
        @(negedge clk);
        #1;
        check("r_byte1", output_axis_tdata, 8'h0A);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("r_tvalid", output_axis_tvalid, 1'b0);
        check("r_tdata", output_axis_tdata, 8'h00);
        check("r_resp_valid", resp_valid, 1'b0);
        check("r_status", resp_status, 2'b00);
        check("r_echo", resp_echo, 8'h00);
        check("r_busy", busy, 1'b0);
        check("r_cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        #1;
        check("r_no_resp", resp_valid, 1'b0);
        @(negedge clk);

        // T7: clean resend from byte0; echo lands on the expiry cycle
        accept_cmd(24'h810A14);
        collect_bytes(0);
        wait_resp(1, TO - 1, 8'h81, TO, 2'b00, 8'h81);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/cmd_sender.md
Name: cmd_sender

Overview:
Host-side counterpart of the levitator's UART command receiver. Accepts a 24-bit command word and serialises it MSB-byte-first onto a byte AXI-stream feeding a UART transmitter. It then waits on the UART receive stream for the device's one-byte echo and reports ok, mismatch, timeout or bad-command. Sits between test/host sequencing logic and a `uart` instance (loopback rigs, PC-bridge FPGA).

Parameters:
DATA_WIDTH, 8, stream byte width (fixed at 8; other values unsupported)
CLOCK, 50000000, system clock Hz
TIMEOUT_CYCLES, CLOCK/100, cycles to wait for echo after last byte accepted (default 10 ms)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_data  in  24  command word; bit 23 is the command marker and must be 1
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
output_axis_tdata  out  8  byte to UART TX
output_axis_tvalid  out  1  byte valid
output_axis_tready  in  1  UART TX accepts byte
input_axis_tdata  in  8  byte from UART RX
input_axis_tvalid  in  1  RX byte valid
input_axis_tready  out  1  consume RX byte
resp_valid  out  1  one-cycle response pulse
resp_status  out  2  00 ok, 01 mismatch, 10 timeout, 11 bad command
resp_echo  out  8  echo byte received (0 for timeout/bad command)
busy  out  1  high in any state but IDLE

Behaviour:
- Reset (sync, rst=1 at clk edge): state IDLE; cmd_ready=0 that cycle; output_axis_tvalid=0, output_axis_tdata=0; input_axis_tready=0; resp_valid=0, resp_status=0, resp_echo=0; busy=0; timer=0. Reset mid-transfer aborts immediately: tvalid drops, no response pulse.
- States: IDLE, SEND0, SEND1, SEND2, WAIT_ECHO, RESP.
- IDLE: cmd_ready=1, input_axis_tready=1; stray RX bytes are consumed and discarded. On cmd_valid with cmd_data[23]=1: latch word; SEND0 next cycle. With cmd_data[23]=0: word accepted, nothing sent; RESP with status 11.
- SENDk (k=0,1,2): tvalid=1, tdata = cmd[23:16], cmd[15:8], cmd[7:0] respectively; data held stable while tvalid & !tready; advance on tvalid & tready; no tvalid bubble between bytes when tready stays high. input_axis_tready=0.
- Latency: command accepted cycle N -> byte0 tvalid cycle N+1; with tready always 1, bytes occupy N+1..N+3; WAIT_ECHO entered N+4.
- WAIT_ECHO: input_axis_tready=1; timer resets to 0 on entry, increments each cycle. First accepted byte: status 00 if equal to cmd[23:16], else 01; resp_echo = byte. If timer reaches TIMEOUT_CYCLES-1 with no byte: status 10. Echo and timeout in same cycle: echo wins.
- RESP: resp_valid=1 for exactly one cycle with status/echo; outputs hold until next RESP. Return to IDLE next cycle. cmd_ready=0 in RESP.
- Timer width $clog2(TIMEOUT_CYCLES)+1; saturates, never wraps.
- cmd_ready is high only in IDLE; back-to-back commands are spaced by at least the RESP cycle.

Decomposition:
- Package fmq_pkg: CMD_WIDTH=24, CMD_MARK_BIT=23, status codes ST_OK/ST_MISMATCH/ST_TIMEOUT/ST_BADCMD, state encoding.
- One natural sub-module: cmd_timeout_timer (clear, enable, expired flag, parameter TIMEOUT_CYCLES).

Test Plan:
- Bench TIMEOUT_CYCLES=100, tready=1. Command 0x81_0A_14; device model echoes 0x81 20 cycles later -> bytes 0x81, 0x0A, 0x14 on cycles N+1..N+3; resp_valid pulse; status 00; echo 0x81.
- Command 0x85_00_FF with tready low 5 cycles per byte -> tdata held stable each stall; no duplicate or lost byte. Echo 0x84 -> status 01, resp_echo 0x84.
- Command 0x90_12_34 with no echo -> resp_valid exactly 100 cycles after WAIT_ECHO entry; status 10; resp_echo 0.
- Command 0x7F_00_00 -> no tvalid ever; resp_valid 1 cycle after accept; status 11.
- Echo arrives on the same cycle the timer expires -> status 00. Stray RX byte 0x55 in IDLE -> consumed, no resp_valid.
- rst pulsed during SEND1 -> tvalid low the next cycle; all outputs at reset values; next command sends cleanly from byte0.
